cacheline_burst_adaptor: RTL and testbench
==========================================

# cacheline_burst_adaptor

- Converts one cache-line request into a fixed-length burst of narrow beats on the physical memory bus.
- Sits directly downstream of the L2 cache arbiter's `l2_*` port, or of the L2 cache's memory side.
- Captures the request address and write data at acceptance.
- Reads assemble `s_line/s_burst` beats into a line; writes serialize the line into beats.
- Each completed transaction returns a single-cycle line response.

## Interface
Parameters:
- `s_offset`, default 5: line offset bits; the burst address has these bits forced to 0.
- `s_line`, default 256: line width in bits.
- `s_burst`, default 64: beat width in bits. `s_line` must be an integer multiple of `s_burst`; default gives 4 beats, `s_beats = s_line/s_burst`.

Ports:
- `clk` in 1: the block's only clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_read` in 1: line read request; held by upstream until `line_resp`.
- `line_write` in 1: line write request; held by upstream until `line_resp`.
- `line_address` in 32: byte address of the line.
- `line_wdata` in `s_line`: write line; beat k is bits `[k*s_burst +: s_burst]`.
- `line_resp` out 1: one-cycle completion pulse.
- `line_rdata` out `s_line`: assembled read line.
- `burst_read` out 1: memory read burst request.
- `burst_write` out 1: memory write burst request.
- `burst_address` out 32: latched line address with `[s_offset-1:0]` = 0.
- `burst_wdata` out `s_burst`: current write beat.
- `burst_rdata` in `s_burst`: read beat, valid when `burst_resp`=1.
- `burst_resp` in 1: beat accept/valid strobe from memory.

## Operation
States and transitions:
- **IDLE**
  - `line_read` → READ.
  - else `line_write` → WRITE.
  - On acceptance: latch the aligned address into `addr_q`, latch `line_wdata` into `wdata_q` (writes), clear beat counter `cnt` to 0.
- **READ**
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1: store `burst_rdata` into `rdata_q[cnt*s_burst +: s_burst]`, then `cnt` += 1.
  - On the beat where `cnt` = `s_beats`-1 → DONE.
- **WRITE**
  - `burst_write`=1; `burst_wdata` = `wdata_q[cnt*s_burst +: s_burst]`, combinational from `cnt`.
  - Each `burst_resp`=1 advances `cnt`.
  - Last beat → DONE.
- **DONE**
  - `line_resp`=1 for this one cycle only; then → IDLE.

Output and request rules:
- `line_rdata` = `rdata_q`; holds its value until beats of the next read overwrite it.
- `burst_address` = `addr_q`; stable for the whole burst.
- Both `line_read` and `line_write` asserted in IDLE: read wins; the write is not performed for that request.
- Request inputs are ignored outside IDLE. Upstream changes to address or wdata mid-burst have no effect.
- Beats need not be consecutive. Cycles in READ or WRITE with `burst_resp`=0 change nothing.
- `cnt` is `$clog2(s_beats)` bits and never wraps inside a burst; the exit to DONE happens at `s_beats`-1.
- `burst_read` and `burst_write` are never both 1.
- `burst_resp` in IDLE or DONE is ignored.

## Timing
- Request sampled high in IDLE at edge E0 → `burst_read`/`burst_write` high from cycle 1.
- Back-to-back beats in cycles 1..4 → DONE in cycle 5, `line_resp`=1 in cycle 5, `line_rdata` valid in cycle 5.
- Minimum latency, request to `line_resp`: `s_beats`+1 cycles. Each `burst_resp`=0 cycle adds one.
- After DONE, IDLE lasts at least one cycle. A request still held there, or a new request, is accepted at that cycle's edge: minimum request-to-request spacing is `s_beats`+2 cycles.
- Reset values, applied immediately on `rst_n`=0, including mid-burst:
  - state IDLE, `cnt`=0.
  - `addr_q`=0, `wdata_q`=0, `rdata_q`=0.
  - Outputs: `burst_read`=0, `burst_write`=0, `line_resp`=0, `line_rdata`=0, `burst_address`=0, `burst_wdata`=0.
- An aborted burst is not resumed. Upstream must reissue the request.

## Test plan
- **Read, back-to-back beats**
  - Stimulus: `line_read`, `line_address`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `burst_address`=0x0000_1220; `line_resp` in cycle 5; `line_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write with gaps**
  - Stimulus: `line_write`, `line_wdata` = {D3,D2,D1,D0}; memory strobes `burst_resp` at cycles 1, 3, 4, 7.
  - Required: `burst_wdata` = D0, D1, D2, D3 at each strobe; `line_resp` only at cycle 8; `burst_write` low from cycle 8.
- **Simultaneous read and write**
  - Stimulus: `line_read` and `line_write` both high.
  - Required: `burst_read`=1, `burst_write`=0 throughout; response after 4 beats.
- **Input change mid-burst**
  - Stimulus: change `line_address` and `line_wdata` during cycle 2 of a write.
  - Required: `burst_address` and remaining beats unchanged.
- **Reset mid-burst**
  - Stimulus: deassert `rst_n` after 2 read beats.
  - Required: `burst_read`=0 and `line_rdata`=0 immediately, before the next clock edge; a fresh read after reset completes in 5 cycles with correct data.
- **Back-to-back requests**
  - Stimulus: hold `line_read` across a response.
  - Required: a second burst starts with `burst_read` high in cycle 7; `line_resp` pulses in cycles 5 and 11.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// Turns one cache-line read or write into a fixed-length burst of narrow
// beats on the memory bus. Reads gather beats into a line register, writes
// play the captured line out one beat at a time. Every finished line
// transaction ends with a one-cycle line_resp pulse.
module cacheline_burst_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [31:0]         line_address,
  input  logic [s_line-1:0]   line_wdata,
  output logic                line_resp,
  output logic [s_line-1:0]   line_rdata,
  output logic                burst_read,
  output logic                burst_write,
  output logic [31:0]         burst_address,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam int s_beats = s_line / s_burst;
  // Keep the counter at least one bit wide so a single-beat line still builds.
  localparam int cnt_w = (s_beats > 1) ? $clog2(s_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(s_beats - 1);
  localparam logic [31:0] align_mask = ~((32'h1 << s_offset) - 32'h1);

  typedef enum logic [1:0] {
    st_idle,
    st_read,
    st_write,
    st_done
  } state_t;

  state_t              state_reg;
  logic [cnt_w-1:0]    cnt_reg;
  logic [31:0]         addr_reg;
  logic [s_line-1:0]   wdata_reg;
  logic [s_line-1:0]   rdata_reg;
  logic                burst_read_reg;
  logic                burst_write_reg;
  logic                line_resp_reg;

  // Captured write line viewed as an array of beats so the beat select is a plain mux.
  logic [s_burst-1:0]  wbeat [s_beats];

  genvar gi;
  generate
    for (gi = 0; gi < s_beats; gi++) begin : g_wbeat
      assign wbeat[gi] = wdata_reg[gi*s_burst +: s_burst];
    end
  endgenerate

  // Sequencer: accept a request in idle, count beats, pulse the response, return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= st_idle;
      cnt_reg         <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      burst_read_reg  <= 1'b0;
      burst_write_reg <= 1'b0;
      line_resp_reg   <= 1'b0;
    end else begin
      line_resp_reg <= 1'b0;
      case (state_reg)
        st_idle: begin
          // Read has priority when both requests are raised together.
          if (line_read) begin
            state_reg      <= st_read;
            addr_reg       <= line_address & align_mask;
            cnt_reg        <= '0;
            burst_read_reg <= 1'b1;
          end else if (line_write) begin
            state_reg       <= st_write;
            addr_reg        <= line_address & align_mask;
            wdata_reg       <= line_wdata;
            cnt_reg         <= '0;
            burst_write_reg <= 1'b1;
          end
        end
        st_read: begin
          if (burst_resp) begin
            for (int b = 0; b < s_beats; b++) begin
              if (cnt_reg == cnt_w'(b)) begin
                rdata_reg[b*s_burst +: s_burst] <= burst_rdata;
              end
            end
            // The counter stops on the last beat instead of wrapping.
            if (cnt_reg == last_beat) begin
              state_reg      <= st_done;
              burst_read_reg <= 1'b0;
              line_resp_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        st_write: begin
          if (burst_resp) begin
            if (cnt_reg == last_beat) begin
              state_reg       <= st_done;
              burst_write_reg <= 1'b0;
              line_resp_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        st_done: begin
          state_reg <= st_idle;
        end
        default: begin
          state_reg <= st_idle;
        end
      endcase
    end
  end

  assign line_resp     = line_resp_reg;
  assign line_rdata    = rdata_reg;
  assign burst_read    = burst_read_reg;
  assign burst_write   = burst_write_reg;
  assign burst_address = addr_reg;
  assign burst_wdata   = wbeat[cnt_reg];

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: directed scenarios followed by random
// transactions, each compared against a line-level model of the expected
// beats, address, response cycle and returned line.
module tb_cacheline_burst_adaptor;

  localparam int OFFS  = 5;
  localparam int LINE  = 256;
  localparam int BW    = 64;
  localparam int BEATS = LINE / BW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             line_read;
  logic             line_write;
  logic [31:0]      line_address;
  logic [LINE-1:0]  line_wdata;
  logic             line_resp;
  logic [LINE-1:0]  line_rdata;
  logic             burst_read;
  logic             burst_write;
  logic [31:0]      burst_address;
  logic [BW-1:0]    burst_wdata;
  logic [BW-1:0]    burst_rdata;
  logic             burst_resp;

  int n_cmp = 0;
  int n_err = 0;
  logic [LINE-1:0] last_rline = '0;

  cacheline_burst_adaptor #(.s_offset(OFFS), .s_line(LINE), .s_burst(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_resp(line_resp), .line_rdata(line_rdata),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE-1:0] rand_line();
    logic [LINE-1:0] v;
    for (int i = 0; i < LINE / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_burst_read"}, burst_read, 0);
    check({tag, "_burst_write"}, burst_write, 0);
    check({tag, "_line_resp"}, line_resp, 0);
    check({tag, "_line_rdata"}, line_rdata, 0);
    check({tag, "_burst_address"}, burst_address, 0);
    check({tag, "_burst_wdata"}, burst_wdata, 0);
  endtask

  // Called at a falling edge while the DUT is idle. kind: 0 read, 1 write, 2 both.
  // mask bit i = memory strobes burst_resp in burst cycle i+1.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [LINE-1:0] wline,
                         input logic [LINE-1:0] rline, input logic [31:0] mask,
                         input bit mid_change, input bit hold);
    logic [31:0] exp_addr;
    int done_cyc;
    int seen;
    int k;
    bit done;
    bit strobe;
    exp_addr = addr & ~((32'h1 << OFFS) - 32'h1);
    seen = 0;
    done_cyc = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        seen++;
        if (seen == BEATS && done_cyc == 0) done_cyc = i + 2;
      end
    end
    line_read    = (kind != 1);
    line_write   = (kind != 0);
    line_address = addr;
    line_wdata   = wline;
    burst_resp   = 1'b0;
    k = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (k == BEATS) begin
        check("resp_pulse", line_resp, 1);
        check("resp_cycle", c, done_cyc);
        check("done_burst_read", burst_read, 0);
        check("done_burst_write", burst_write, 0);
        if (kind != 1) last_rline = rline;
        check("line_rdata", line_rdata, last_rline);
        $display("txn kind=%0d addr=%h resp_cycle=%0d", kind, addr, c);
        burst_resp = 1'b0;
        if (!hold) begin
          line_read  = 1'b0;
          line_write = 1'b0;
        end
        done = 1'b1;
      end else begin
        check("burst_read", burst_read, kind != 1);
        check("burst_write", burst_write, kind == 1);
        check("no_resp", line_resp, 0);
        check("burst_address", burst_address, exp_addr);
        if (kind == 1) check("burst_wdata", burst_wdata, wline[k*BW +: BW]);
        if (mid_change && c == 2) begin
          line_address = ~addr;
          line_wdata   = ~wline;
        end
        strobe = (c <= 32) ? mask[c-1] : 1'b0;
        burst_resp  = strobe;
        burst_rdata = strobe ? rline[k*BW +: BW] : {$urandom, $urandom};
        if (strobe) k++;
      end
    end
    check("txn_completed", done, 1);
    // One idle cycle always follows the response.
    @(negedge clk);
    check("idle_burst_read", burst_read, 0);
    check("idle_burst_write", burst_write, 0);
    check("idle_resp", line_resp, 0);
  endtask

  initial begin
    logic [LINE-1:0] wl;
    logic [LINE-1:0] rl;
    rst_n        = 1'b0;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Read, back-to-back beats, test-plan data.
    rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(0, 32'h0000_1234, '0, rl, 32'h0000_000F, 1'b0, 1'b0);

    // Write with strobes in cycles 1, 3, 4, 7.
    wl = rand_line();
    run_txn(1, 32'hDEAD_BEEF, wl, '0, 32'h0000_004D, 1'b0, 1'b0);

    // Read and write together: read wins.
    rl = rand_line();
    run_txn(2, 32'h0000_8040, rand_line(), rl, 32'h0000_000F, 1'b0, 1'b0);

    // Address/data change during cycle 2 of a write.
    wl = rand_line();
    run_txn(1, 32'h1357_9BDF, wl, '0, 32'h0000_00B5, 1'b1, 1'b0);

    // Reset after two read beats.
    line_read    = 1'b1;
    line_address = 32'hCAFE_0010;
    @(negedge clk);
    burst_resp = 1'b1; burst_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    burst_rdata = 64'h5555_6666_7777_8888;
    @(negedge clk);
    burst_resp = 1'b0;
    check("pre_reset_burst_read", burst_read, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    line_read = 1'b0;
    last_rline = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
    rl = rand_line();
    run_txn(0, 32'h0000_2468, '0, rl, 32'h0000_000F, 1'b0, 1'b0);

    // Back-to-back: request held across the response; second burst starts in cycle 7.
    rl = rand_line();
    run_txn(0, 32'h0000_4000, '0, rl, 32'h0000_000F, 1'b0, 1'b1);
    rl = rand_line();
    run_txn(0, 32'h0000_4000, '0, rl, 32'h0000_000F, 1'b0, 1'b0);

    // Random transactions.
    for (int t = 0; t < 25; t++) begin
      int kind;
      logic [31:0] m;
      kind = $urandom_range(0, 2);
      m = $urandom | 32'hF000_0000;
      run_txn(kind, $urandom, rand_line(), rand_line(), m, $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
